prio_arb_mux: RTL

- Parametrised, registered successor to the team's 4-input enable-priority mux.
- Selects one of N_CH valid/ready input channels, each WIDTH bits wide, and delivers it through a one-entry output register.
- Arbitration is either fixed priority (highest index wins) or round-robin.
- Sits between multiple producers and a single downstream consumer.

---
 rtl/prio_arb_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/prio_arb_mux.sv
// N_CH-to-1 valid/ready arbiter with a one-entry registered output stage.
// Fixed priority favours the highest index; round-robin demotes the last winner.
module prio_arb_mux #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int RR_MODE = 0,
  parameter int CHW     = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CHW-1:0]        out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] chan_data [N_CH];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]   out_ch_q,    out_ch_d;
  logic [CHW-1:0]   ptr_q,       ptr_d;

  logic             load;
  logic             take;
  logic             grant_vld;
  logic [CHW-1:0]   grant_idx;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // The output register can accept a beat when empty or when it drains this cycle.
  assign load = ~out_valid_q | out_ready;
  assign take = grant_vld & load;

  always_comb begin
    logic [CHW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N_CH; i++) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = CHW'(i);
        end
      end
    end else begin
      // Walk from the lowest-priority offset toward ptr so the nearest valid channel wins last.
      for (int k = N_CH - 1; k >= 0; k--) begin
        cand = CHW'((int'(ptr_q) + N_CH - k) % N_CH);
        if (in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = take;
      if (take) begin
        out_data_d = chan_data[grant_idx];
        out_ch_d   = grant_idx;
        if (RR_MODE != 0) begin
          ptr_d = (grant_idx == '0) ? CHW'(N_CH - 1) : grant_idx - CHW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CHW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
